skolem_sweep_ctrl: RTL and testbench
====================================

// Module: skolem_sweep_ctrl
// PURPOSE
// Exhaustive sweep sequencer for a combinational Skolem-function block (N_IN universal inputs -> N_OUT
// existential outputs). Drives every input assignment 0..2^N_IN-1 into the Skolem block and samples
// an external spec evaluator's verdict LAT cycles later. Counts failures, records the first failing
// assignment and reports pass/fail. Sits between the bench/host control and the Skolem+spec datapath.
// PARAMETERS
// N_IN    6   width of universal input vector (sweep space 2^N_IN)
// N_OUT   10  width of Skolem output vector (observed only for first-fail capture)
// LAT     0   cycles from x_out driven to spec_ok valid (0..7; 0 = purely combinational path)
// PORTS
// clk            in   1          clock; all state updates on rising edge
// rst            in   1          synchronous, active-high reset
// start          in   1          begin sweep; sampled only in IDLE
// pause          in   1          while high in RUN, no new vector issued; in-flight checks still retire
// x_out          out  N_IN       assignment driven to Skolem block
// x_valid        out  1          x_out is a live vector this cycle
// y_in           in   N_OUT      Skolem outputs for the vector issued LAT cycles earlier
// spec_ok        in   1          spec verdict for the same vector; 1 = satisfied
// busy           out  1          high in RUN and DRAIN
// done           out  1          one-cycle pulse when the sweep completes
// pass           out  1          1 when last completed sweep had zero failures; held until next start
// fail_count     out  N_IN+1     failures in current/last sweep (max 2^N_IN, no wrap)
// first_fail_vld out  1          a failure has been recorded this sweep
// first_fail_x   out  N_IN       assignment of the first failure
// first_fail_y   out  N_OUT      y_in captured with the first failure
// BEHAVIOUR
// - Reset: state IDLE; x_out=0, x_valid=0, busy=0, done=0, pass=0, fail_count=0, first_fail_vld=0,
//   first_fail_x=0, first_fail_y=0; check pipeline valid bits cleared. Reset mid-sweep abandons all
//   in-flight checks; no done pulse.
// - FSM: IDLE -start-> RUN (clears fail_count, first_fail_*, pass). RUN -last vector issued-> DRAIN.
//   DRAIN -no checks outstanding-> DONE. DONE -> IDLE after one cycle (done=1 only in DONE).
// - start in RUN/DRAIN/DONE ignored. start held high in IDLE after DONE starts a new sweep.
// - RUN issue: each cycle with pause=0, x_valid=1 and x_out=issue counter; counter then increments.
//   pause=1: x_valid=0, x_out holds. First vector 0 in cycle after start accepted.
// - Check alignment: LAT-deep shift register of {valid, x}; a check retires at the edge ending the
//   cycle its valid bit reaches stage LAT (LAT=0: same cycle as issue). Retiring with spec_ok=0:
//   fail_count+1; if first_fail_vld=0, capture x, y_in, set first_fail_vld.
// - spec_ok/y_in ignored in cycles with no retiring check.
// - Vector 2^N_IN-1 is the last; issue counter never wraps into a second pass.
// - Timing (no pause, start sampled in cycle t): vectors in cycles t+1..t+2^N_IN; done in cycle
//   t+2^N_IN+LAT+1; each pause cycle in RUN delays done by one cycle.
// - pass set in DONE cycle iff fail_count==0; visible together with done.
// - busy=1 in RUN and DRAIN, 0 in IDLE and DONE.
// TESTING
// 1 LAT=0, spec_ok tied 1, start at t -> x_out 0..63 in t+1..t+64, done at t+65, pass=1, fail_count=0.
// 2 LAT=0, spec_ok=0 only for x=5 and x=40 -> fail_count=2, first_fail_x=5, first_fail_y=y_in at x=5,
//   pass=0.
// 3 LAT=2, pause high for 3 cycles at x=10 -> each vector issued once, done at t+64+2+1+3=t+70.
// 4 LAT=3, fail only on x=63 -> failure retires in DRAIN, fail_count=1, first_fail_x=63, done at
//   t+68.
// 5 rst asserted when x_out=30 -> next cycle all outputs at reset values, no done; new start gives
//   full 64-vector sweep.
// 6 start pulsed during RUN and DRAIN -> ignored, single done pulse, counts unaffected.

Source files
------------

// File: rtl/skolem_sweep_ctrl.sv
// skolem_sweep_ctrl: exhaustive input sweep of a Skolem block with latency-aligned verdict checking
module skolem_sweep_ctrl #(
  parameter int N_IN  = 6,
  parameter int N_OUT = 10,
  parameter int LAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  output logic [N_IN-1:0]  x_out,
  output logic             x_valid,
  input  logic [N_OUT-1:0] y_in,
  input  logic             spec_ok,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    fail_count,
  output logic             first_fail_vld,
  output logic [N_IN-1:0]  first_fail_x,
  output logic [N_OUT-1:0] first_fail_y
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  localparam logic [N_IN-1:0] LAST = '1;
  state_t state, state_n;
  logic [N_IN-1:0] cnt;
  logic [N_IN-1:0] ret_x;
  logic ret_v, pend, pass_r;
  assign x_out   = cnt;
  assign x_valid = state == RUN && !pause;
  assign busy    = state == RUN || state == DRAIN;
  assign done    = state == DONE;
  assign pass    = done ? fail_count == '0 : pass_r;
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (start ? RUN : IDLE) :
              state == RUN   ? ((x_valid && cnt == LAST) ? (LAT == 0 ? DONE : DRAIN) : RUN) :
              state == DRAIN ? (pend ? DRAIN : DONE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // Issue counter parks on the last vector so a sweep never wraps into a second pass
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      fail_count     <= '0;
      first_fail_vld <= 1'b0;
      first_fail_x   <= '0;
      first_fail_y   <= '0;
      pass_r         <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt            <= '0;
      fail_count     <= '0;
      first_fail_vld <= 1'b0;
      first_fail_x   <= '0;
      first_fail_y   <= '0;
      pass_r         <= 1'b0;
    end else begin
      if (x_valid && cnt != LAST) cnt <= cnt + 1'b1;
      if (ret_v && !spec_ok) begin
        fail_count <= fail_count + 1'b1;
        if (!first_fail_vld) begin
          first_fail_vld <= 1'b1;
          first_fail_x   <= ret_x;
          first_fail_y   <= y_in;
        end
      end
      if (done) pass_r <= fail_count == '0;
    end
  end
  // Stage k of the check pipe holds the vector issued k cycles ago; stage LAT retires
  if (LAT == 0) begin : g_comb
    assign ret_v = x_valid;
    assign ret_x = x_out;
    assign pend  = 1'b0;
  end else begin : g_pipe
    logic [LAT-1:0]  sv;
    logic [N_IN-1:0] sx [LAT];
    always_ff @(posedge clk) begin
      if (rst) sv <= '0;
      else begin
        sv[0] <= x_valid;
        for (int i = 1; i < LAT; i++) sv[i] <= sv[i-1];
      end
      sx[0] <= x_out;
      for (int i = 1; i < LAT; i++) sx[i] <= sx[i-1];
    end
    always_comb begin
      pend = 1'b0;
      for (int i = 0; i < LAT - 1; i++) pend = pend | sv[i];
    end
    assign ret_v = sv[LAT-1];
    assign ret_x = sx[LAT-1];
  end
endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// tb_skolem_sweep_ctrl: three sweep controllers (LAT 0/2/3) against a modelled Skolem+spec datapath
module tb_skolem_sweep_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pause = 1'b0;
  logic [5:0] x_out [3];
  logic [5:0] ffx [3];
  logic [9:0] y_in [3];
  logic [9:0] ffy [3];
  logic [6:0] fc [3];
  logic [2:0] x_valid, spec_ok, busy, done, pass, ffv, pass_d;
  logic [63:0] fail_mask = '0;
  logic [5:0] q [$];
  int cyc = 0, total = 0, bad = 0;
  int done_n [3];
  int done_c [3];
  typedef struct {
    logic [63:0] fm;
    int pa;
    int pl;
    bit pulses;
    int exp_cnt;
    int exp_ffx;
  } vec_t;
  vec_t tbl [6];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [9:0] yf(input logic [5:0] x);
    return 10'(x * 37 + 11);
  endfunction
  function automatic int lat(input int g);
    return g == 0 ? 0 : g + 1;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int L = g == 0 ? 0 : g + 1;
    logic [5:0] h1, h2, h3, dx;
    always @(posedge clk) begin
      h1 <= x_out[g];
      h2 <= h1;
      h3 <= h2;
    end
    assign dx = L == 0 ? x_out[g] : L == 2 ? h2 : h3;
    assign spec_ok[g] = !fail_mask[dx];
    assign y_in[g] = yf(dx);
    skolem_sweep_ctrl #(.N_IN(6), .N_OUT(10), .LAT(L)) u (
      .clk(clk), .rst(rst), .start(start), .pause(pause),
      .x_out(x_out[g]), .x_valid(x_valid[g]), .y_in(y_in[g]), .spec_ok(spec_ok[g]),
      .busy(busy[g]), .done(done[g]), .pass(pass[g]), .fail_count(fc[g]),
      .first_fail_vld(ffv[g]), .first_fail_x(ffx[g]), .first_fail_y(ffy[g])
    );
  end
  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[lat%0d] got=%0d want=%0d", nm, lat(g), act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (|x_valid) begin
      if (q.size() == 0) chk("extra_vector", 0, 32'(x_out[0]), 32'hffff_ffff);
      else begin
        logic [5:0] e;
        e = q.pop_front();
        for (int g = 0; g < 3; g++) begin
          chk("x_valid", g, 32'(x_valid[g]), 1);
          chk("x_out", g, 32'(x_out[g]), 32'(e));
        end
      end
    end
    for (int g = 0; g < 3; g++)
      if (done[g]) begin
        done_n[g]++;
        done_c[g] = cyc;
        pass_d[g] = pass[g];
      end
  end
  task automatic check_reset();
    for (int g = 0; g < 3; g++) begin
      chk("rst_x_out", g, 32'(x_out[g]), 0);
      chk("rst_x_valid", g, 32'(x_valid[g]), 0);
      chk("rst_busy", g, 32'(busy[g]), 0);
      chk("rst_done", g, 32'(done[g]), 0);
      chk("rst_pass", g, 32'(pass[g]), 0);
      chk("rst_fail_count", g, 32'(fc[g]), 0);
      chk("rst_ff_vld", g, 32'(ffv[g]), 0);
      chk("rst_ff_x", g, 32'(ffx[g]), 0);
      chk("rst_ff_y", g, 32'(ffy[g]), 0);
    end
  endtask
  task automatic begin_sweep(input logic [63:0] fm, output int t);
    @(posedge clk); #1;
    t = cyc;
    fail_mask = fm;
    start = 1'b1;
    for (int i = 0; i < 64; i++) q.push_back(6'(i));
    for (int g = 0; g < 3; g++) begin
      done_n[g] = 0;
      done_c[g] = -1;
    end
  endtask
  task automatic run_case(input vec_t c);
    int t;
    logic [9:0] ey;
    begin_sweep(c.fm, t);
    for (int k = 0; k < 120; k++) begin
      @(posedge clk); #1;
      start = c.pulses && (cyc == t + 20 || cyc == t + 65 + c.pl);
      pause = cyc >= t + 1 + c.pa && cyc < t + 1 + c.pa + c.pl;
    end
    start = 1'b0;
    pause = 1'b0;
    ey = c.exp_cnt != 0 ? yf(6'(c.exp_ffx)) : 10'd0;
    for (int g = 0; g < 3; g++) begin
      chk("done_pulses", g, done_n[g], 1);
      chk("done_cycle", g, done_c[g], t + 65 + lat(g) + c.pl);
      chk("fail_count", g, 32'(fc[g]), c.exp_cnt);
      chk("ff_vld", g, 32'(ffv[g]), 32'(c.exp_cnt != 0));
      chk("ff_x", g, 32'(ffx[g]), c.exp_ffx);
      chk("ff_y", g, 32'(ffy[g]), 32'(ey));
      chk("pass_at_done", g, 32'(pass_d[g]), 32'(c.exp_cnt == 0));
      chk("pass_held", g, 32'(pass[g]), 32'(c.exp_cnt == 0));
      chk("busy_idle", g, 32'(busy[g]), 0);
    end
    chk("vectors_missing", 0, q.size(), 0);
    q.delete();
  endtask
  initial begin
    int t;
    tbl[0] = '{64'h0, 0, 0, 1'b0, 0, 0};
    tbl[1] = '{64'h0000_0100_0000_0020, 0, 0, 1'b0, 2, 5};
    tbl[2] = '{64'h0, 10, 3, 1'b0, 0, 0};
    tbl[3] = '{64'h8000_0000_0000_0000, 0, 0, 1'b0, 1, 63};
    tbl[4] = '{64'h8000_0000_0000_0001, 30, 1, 1'b1, 2, 0};
    tbl[5] = '{64'hffff_ffff_ffff_ffff, 0, 0, 1'b0, 64, 0};
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) run_case(tbl[i]);
    begin_sweep(64'h8, t);
    while (cyc < t + 31) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    check_reset();
    repeat (80) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) chk("done_after_rst", g, done_n[g], 0);
    chk("vectors_after_rst", 0, q.size(), 0);
    run_case(tbl[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
